// File: rtl/vga_pkg.sv
`default_nettype none
// =====================================================================
// vga_pkg : video timing sets and helpers shared by the scanout blocks
// Revision 1.0 - initial release
// =====================================================================
package vga_pkg;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;

  typedef enum logic [1:0] {
    MODE_640X480  = 2'd0,
    MODE_800X600  = 2'd1,
    MODE_1024X768 = 2'd2
  } vga_mode_t;

  typedef struct packed {
    int h_vis;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_vis;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480 = '{
    h_vis: 640, h_fp: 16, h_sync: 96, h_bp: 48,
    v_vis: 480, v_fp: 10, v_sync: 2, v_bp: 33
  };

  localparam vga_timing_t VGA_800X600 = '{
    h_vis: 800, h_fp: 40, h_sync: 128, h_bp: 88,
    v_vis: 600, v_fp: 1, v_sync: 4, v_bp: 23
  };

  localparam vga_timing_t VGA_1024X768 = '{
    h_vis: 1024, h_fp: 24, h_sync: 136, h_bp: 160,
    v_vis: 768, v_fp: 3, v_sync: 6, v_bp: 29
  };

  function automatic int total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic vga_timing_t timing_of(input vga_mode_t mode);
    case (mode)
      MODE_800X600:  return VGA_800X600;
      MODE_1024X768: return VGA_1024X768;
      default:       return VGA_640X480;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_scanout_if.sv
`default_nettype none
// =====================================================================
// vga_scanout_if : pixel fetch bus between scanout and framebuffer
// Revision 1.0 - initial release
// =====================================================================
interface vga_scanout_if
  import vga_pkg::*;
#(
  parameter int BPC = 4
) ();

  logic [HCNT_W-1:0] x;
  logic [VCNT_W-1:0] y;
  logic              fetch_de;
  logic [3*BPC-1:0]  pix;

  modport master (output x, output y, output fetch_de, input pix);
  modport slave  (input x, input y, input fetch_de, output pix);

endinterface
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// =====================================================================
// vga_delay : clock-enabled shift register, DEPTH stages of WIDTH bits
// Revision 1.0 - initial release
// =====================================================================
module vga_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (ce) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_scanout.sv
`default_nettype none
// =====================================================================
// vga_scanout : parametrised VGA timing, framebuffer fetch, aligned RGB
// Revision 1.0 - initial release
// =====================================================================
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_VIS  = VGA_640X480.h_vis,
  parameter int H_FP   = VGA_640X480.h_fp,
  parameter int H_SYNC = VGA_640X480.h_sync,
  parameter int H_BP   = VGA_640X480.h_bp,
  parameter int V_VIS  = VGA_640X480.v_vis,
  parameter int V_FP   = VGA_640X480.v_fp,
  parameter int V_SYNC = VGA_640X480.v_sync,
  parameter int V_BP   = VGA_640X480.v_bp,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int BPC    = 4,
  parameter int LAT    = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           ce,
  vga_scanout_if.master  fb,
  output logic [BPC-1:0] r,
  output logic [BPC-1:0] g,
  output logic [BPC-1:0] b,
  output logic           hs,
  output logic           vs,
  output logic           de,
  output logic           frame
);

  localparam int H_TOTAL = total(H_VIS, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_VIS, V_FP, V_SYNC, V_BP);

  // One bit wider than the counters so a 2048/1024 total still compares cleanly
  localparam logic [HCNT_W:0]   H_VIS_C  = (HCNT_W+1)'(H_VIS);
  localparam logic [HCNT_W:0]   HS_BEG   = (HCNT_W+1)'(H_VIS + H_FP);
  localparam logic [HCNT_W:0]   HS_END   = (HCNT_W+1)'(H_VIS + H_FP + H_SYNC);
  localparam logic [VCNT_W:0]   V_VIS_C  = (VCNT_W+1)'(V_VIS);
  localparam logic [VCNT_W:0]   VS_BEG   = (VCNT_W+1)'(V_VIS + V_FP);
  localparam logic [VCNT_W:0]   VS_END   = (VCNT_W+1)'(V_VIS + V_FP + V_SYNC);
  localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
  localparam logic              HS_ACT   = (HS_POL != 0);
  localparam logic              VS_ACT   = (VS_POL != 0);

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_scanout: H_TOTAL/V_TOTAL exceed the 11/10-bit counter range");
  end
  if (LAT < 1 || LAT > 8) begin : g_bad_lat
    $error("vga_scanout: LAT must be within 1..8");
  end

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (ce) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  logic [HCNT_W:0] w_h;
  logic [VCNT_W:0] w_v;
  logic            w_fetch_de;
  logic            w_hs_raw;
  logic            w_vs_raw;
  logic            w_frame_raw;

  assign w_h         = {1'b0, hcnt_q};
  assign w_v         = {1'b0, vcnt_q};
  assign w_fetch_de  = (w_h < H_VIS_C) && (w_v < V_VIS_C);
  assign w_hs_raw    = (w_h >= HS_BEG) && (w_h < HS_END);
  assign w_vs_raw    = (w_v >= VS_BEG) && (w_v < VS_END);
  assign w_frame_raw = (hcnt_q == '0) && (vcnt_q == '0);

  assign fb.fetch_de = w_fetch_de;
  assign fb.x        = w_fetch_de ? hcnt_q : '0;
  assign fb.y        = w_fetch_de ? vcnt_q : '0;

  // Delayed flags are active-high: {frame, vs, hs, de}; polarity applied at the pins
  logic [3:0] w_dly;

  vga_delay #(
    .DEPTH (LAT),
    .WIDTH (4)
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .din   ({w_frame_raw, w_vs_raw, w_hs_raw, w_fetch_de}),
    .dout  (w_dly)
  );

  logic [BPC-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic           hs_q, hs_d, vs_q, vs_d, de_q, de_d, frame_q, frame_d;

  always_comb begin
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = de_q;
    frame_d = frame_q;
    if (ce) begin
      de_d    = w_dly[0];
      hs_d    = w_dly[1] ? HS_ACT : ~HS_ACT;
      vs_d    = w_dly[2] ? VS_ACT : ~VS_ACT;
      frame_d = w_dly[3];
      if (w_dly[0]) begin
        {r_d, g_d, b_d} = fb.pix;
      end else begin
        {r_d, g_d, b_d} = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hs_q    <= ~HS_ACT;
      vs_q    <= ~VS_ACT;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      frame_q <= frame_d;
    end
  end

  assign r     = r_q;
  assign g     = g_q;
  assign b     = b_q;
  assign hs    = hs_q;
  assign vs    = vs_q;
  assign de    = de_q;
  assign frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// =====================================================================
// tb_vga_scanout : directed checks of three scanout configurations
// Revision 1.0 - initial release
// =====================================================================
module tb_vga_scanout;
  import vga_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst2, ce0, ce1, ce2;
  logic [3:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic hs0, vs0, de0, frame0, hs1, vs1, de1, frame1, hs2, vs2, de2, frame2;

  vga_scanout_if #(.BPC(4)) fb0 ();
  vga_scanout_if #(.BPC(4)) fb1 ();
  vga_scanout_if #(.BPC(4)) fb2 ();

  vga_scanout dut0 (
    .clock(clk), .reset(rst0), .ce(ce0), .fb(fb0),
    .r(r0), .g(g0), .b(b0), .hs(hs0), .vs(vs0), .de(de0), .frame(frame0)
  );

  vga_scanout #(
    .H_VIS(VGA_800X600.h_vis), .H_FP(VGA_800X600.h_fp),
    .H_SYNC(VGA_800X600.h_sync), .H_BP(VGA_800X600.h_bp),
    .V_VIS(VGA_800X600.v_vis), .V_FP(VGA_800X600.v_fp),
    .V_SYNC(VGA_800X600.v_sync), .V_BP(VGA_800X600.v_bp),
    .HS_POL(1), .VS_POL(1), .LAT(4)
  ) dut1 (
    .clock(clk), .reset(rst0), .ce(ce1), .fb(fb1),
    .r(r1), .g(g1), .b(b1), .hs(hs1), .vs(vs1), .de(de1), .frame(frame1)
  );

  // Tiny raster: 16 clocks per line, 8 lines per frame
  vga_scanout #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut2 (
    .clock(clk), .reset(rst2), .ce(ce2), .fb(fb2),
    .r(r2), .g(g2), .b(b2), .hs(hs2), .vs(vs2), .de(de2), .frame(frame2)
  );

  // Framebuffer model for dut0: two enabled cycles of read latency
  logic [11:0] fb_pipe [2] = '{12'h000, 12'h000};
  bit pix_white = 1'b0;
  always @(posedge clk) begin
    if (ce0) begin
      fb_pipe[0] <= {fb0.x[3:0], fb0.y[3:0], fb0.x[7:4]};
      fb_pipe[1] <= fb_pipe[0];
    end
  end
  assign fb0.pix = pix_white ? 12'hFFF : fb_pipe[1];
  assign fb1.pix = 12'h000;
  assign fb2.pix = 12'hABC;

  int n_cmp = 0;
  int n_fail = 0;
  int hold_viol = 0;
  bit ce0_alt = 1'b0;

  localparam int S_HS0 = 0, S_DE0 = 1, S_FR0 = 2, S_HS1 = 3, S_DE1 = 4, S_FDE1 = 5, S_VS2 = 6;

  function automatic logic sig(input int w);
    case (w)
      S_HS0:   return hs0;
      S_DE0:   return de0;
      S_FR0:   return frame0;
      S_HS1:   return hs1;
      S_DE1:   return de1;
      S_FDE1:  return fb1.fetch_de;
      S_VS2:   return vs2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [37:0] out0_vec();
    return {r0, g0, b0, hs0, vs0, de0, frame0, fb0.x, fb0.y, fb0.fetch_de};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // One clock; dut0 outputs must not move across an edge where ce0 was low
  task automatic tick();
    logic        ce_at;
    logic [37:0] snap;
    ce_at = ce0;
    snap  = out0_vec();
    @(posedge clk);
    #1;
    if (ce0_alt) ce0 = ~ce0;
    if (!ce_at && !rst0 && out0_vec() !== snap) hold_viol++;
  endtask

  task automatic wait_level(input int w, input logic lvl, input int max, output int n);
    n = 0;
    while (sig(w) !== lvl && n < max) begin
      tick();
      n++;
    end
    if (sig(w) !== lvl) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_sig%0d: actual timeout after %0d clocks required level %0b", w, max, lvl);
    end
  endtask

  task automatic measure(input int w, input logic act, output int act_len, output int period);
    int d, idle;
    wait_level(w, ~act, 5000, d);
    wait_level(w, act, 5000, d);
    wait_level(w, ~act, 5000, act_len);
    wait_level(w, act, 5000, idle);
    period = act_len + idle;
  endtask

  typedef struct {
    logic        ce;
    logic [10:0] x;
    logic [9:0]  y;
    logic        fde;
    logic        de;
    logic        hs;
    logic        fr;
  } vec_t;

  function automatic vec_t mk(input int c, input int xx, input int yy, input int f,
                              input int d, input int h, input int fr);
    vec_t v;
    v.ce  = c[0];
    v.x   = xx[10:0];
    v.y   = yy[9:0];
    v.fde = f[0];
    v.de  = d[0];
    v.hs  = h[0];
    v.fr  = fr[0];
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    int n, a, p, cnt, viol, frs;

    // ce, x, y, fetch_de | pins: de, hs, frame  (vs stays inactive=1 throughout)
    tbl[0]  = mk(1, 1, 0, 1, 0, 1, 0);
    tbl[1]  = mk(1, 2, 0, 1, 0, 1, 0);
    tbl[2]  = mk(0, 2, 0, 1, 0, 1, 0);
    tbl[3]  = mk(1, 3, 0, 1, 1, 1, 1);
    tbl[4]  = mk(0, 3, 0, 1, 1, 1, 1);
    tbl[5]  = mk(1, 4, 0, 1, 1, 1, 0);
    tbl[6]  = mk(1, 5, 0, 1, 1, 1, 0);
    tbl[7]  = mk(1, 6, 0, 1, 1, 1, 0);
    tbl[8]  = mk(1, 7, 0, 1, 1, 1, 0);
    tbl[9]  = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[10] = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 1, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 1, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[17] = mk(1, 0, 1, 1, 0, 1, 0);
    tbl[18] = mk(1, 1, 1, 1, 0, 1, 0);
    tbl[19] = mk(1, 2, 1, 1, 0, 1, 0);
    tbl[20] = mk(1, 3, 1, 1, 1, 1, 0);

    rst0 = 1'b1; rst2 = 1'b1;
    ce0 = 1'b1; ce1 = 1'b1; ce2 = 1'b1;
    repeat (3) tick();
    chk("rst0_pins", {r0, g0, b0, hs0, vs0, de0, frame0}, {12'h000, 4'b1100});
    chk("rst1_pins", {hs1, vs1, de1, frame1}, 4'b0000);
    chk("rst2_fetch", {fb2.x, fb2.y, fb2.fetch_de}, {11'd0, 10'd0, 1'b1});

    // ---- dut0: default 640x480, LAT=2 ----
    rst0 = 1'b0;
    wait_level(S_FR0, 1'b1, 10, n);
    chk("frame0_latency", n, 3);
    chk("frame0_de", de0, 1'b1);

    for (int l = 1; l <= 5; l++) begin
      wait_level(S_DE0, 1'b0, 1000, n);
      wait_level(S_DE0, 1'b1, 1000, n);
    end
    chk("line5_first_px", {r0, g0, b0}, 12'h050);
    tick();
    chk("line5_second_px", {r0, g0, b0}, 12'h150);
    repeat (638) tick();
    chk("line5_last_px", {de0, r0, g0, b0}, {1'b1, 12'hF57});
    tick();
    chk("line5_after_end", {de0, r0, g0, b0}, 13'h0000);

    measure(S_HS0, 1'b0, a, p);
    chk("hs0_low", a, 96);
    chk("hs0_period", p, 800);

    wait_level(S_DE0, 1'b0, 1000, n);
    cnt = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (de0) cnt++;
    end
    chk("de0_per_line", cnt, 640);

    pix_white = 1'b1;
    cnt = 0; viol = 0;
    for (int i = 0; i < 1600; i++) begin
      tick();
      if (de0) begin
        cnt++;
        if ({r0, g0, b0} !== 12'hFFF) viol++;
      end else if ({r0, g0, b0} !== 12'h000) begin
        viol++;
      end
    end
    chk("blank_violations", viol, 0);
    chk("blank_de_count", cnt, 1280);
    pix_white = 1'b0;

    hold_viol = 0;
    ce0_alt = 1'b1;
    measure(S_HS0, 1'b0, a, p);
    chk("hs0_half_ce_low", a, 192);
    chk("hs0_half_ce_period", p, 1600);
    chk("ce_low_hold", hold_viol, 0);
    ce0_alt = 1'b0;
    ce0 = 1'b1;

    // ---- dut1: 800x600, active-high syncs, LAT=4 ----
    wait_level(S_FDE1, 1'b0, 2000, n);
    wait_level(S_FDE1, 1'b1, 2000, n);
    wait_level(S_DE1, 1'b1, 20, n);
    chk("de1_lag", n, 5);
    measure(S_HS1, 1'b1, a, p);
    chk("hs1_high", a, 128);
    chk("hs1_period", p, 1056);

    // ---- dut2: tiny raster, table-driven ----
    chk("rst2_pins", {r2, g2, b2, hs2, vs2, de2, frame2}, {12'h000, 4'b1100});
    rst2 = 1'b0;
    for (int i = 0; i < 21; i++) begin
      ce2 = tbl[i].ce;
      tick();
      chk($sformatf("vec%0d", i),
          {fb2.x, fb2.y, fb2.fetch_de, de2, hs2, vs2, frame2, r2, g2, b2},
          {tbl[i].x, tbl[i].y, tbl[i].fde, tbl[i].de, tbl[i].hs, 1'b1, tbl[i].fr,
           tbl[i].de ? 12'hABC : 12'h000});
    end
    ce2 = 1'b1;

    cnt = 0; frs = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (de2) cnt++;
      if (frame2) frs++;
    end
    chk("de2_per_frame", cnt, 32);
    chk("frame2_per_frame", frs, 1);

    begin : vs2_measure
      int lo, per;
      lo = 0; per = 0;
      wait_level(S_VS2, 1'b1, 400, n);
      wait_level(S_VS2, 1'b0, 400, n);
      wait_level(S_VS2, 1'b1, 400, lo);
      wait_level(S_VS2, 1'b0, 400, per);
      chk("vs2_low", lo, 32);
      chk("vs2_period", lo + per, 128);
    end

    n = 0;
    while (!(fb2.x == 11'd5 && fb2.y == 10'd2) && n < 300) begin
      tick();
      n++;
    end
    chk("pre_rst_pos", {fb2.x, fb2.y}, {11'd5, 10'd2});
    chk("pre_rst_pins", {de2, r2, g2, b2}, {1'b1, 12'hABC});
    #2 rst2 = 1'b1;
    #1;
    chk("async_rst_pins", {r2, g2, b2, hs2, vs2, de2, frame2}, {12'h000, 4'b1100});
    chk("async_rst_xy", {fb2.x, fb2.y, fb2.fetch_de}, {11'd0, 10'd0, 1'b1});
    tick();
    tick();
    rst2 = 1'b0;
    frs = 0;
    ce2 = 1'b1; tick(); frs += frame2;
    ce2 = 1'b0; tick(); frs += frame2;
    ce2 = 1'b1; tick(); frs += frame2;
    chk("rst_no_early_frame", frs, 0);
    tick();
    chk("rst_frame_pulse", {frame2, de2, fb2.x, fb2.y}, {1'b1, 1'b1, 11'd3, 10'd0});
    tick();
    chk("rst_frame_single", frame2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
